// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and its upstream byte feeder.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port and UART launch port of the feeder, bundled together.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  enable;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;

    // master: host plus UART side; slave: the feeder itself
    modport master (output wr_valid, wr_data, o_busy, input wr_ready, enable, i_data);
    modport slave  (input wr_valid, wr_data, o_busy, output wr_ready, enable, i_data);

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO with occupancy count; reset flushes it by clearing the pointers.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into the UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int INPUT_DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int FIFO_DEPTH       = UART_FIFO_DEPTH,
    parameter  int GAP_CYCLES       = 0,
    parameter  int BUSY_TIMEOUT     = 255,
    localparam int CW               = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_feeder_if.slave       bus,
    output logic [CW-1:0]         fifo_count,
    output logic                  empty,
    output logic                  full,
    output logic                  tx_timeout,
    output logic [15:0]           frames_sent
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYCLES - 1);
    localparam feeder_state_t AFTER_FRAME  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    feeder_state_t               state, state_next;
    logic [TW-1:0]               timer;
    logic [GW-1:0]               gap_cnt;
    logic                        enable_q;
    logic [INPUT_DATA_WIDTH-1:0] i_data_q;
    logic [INPUT_DATA_WIDTH-1:0] head;
    logic                        push;
    logic                        launch;
    logic                        timeout_hit;
    logic                        frame_done;

    assign bus.wr_ready = !full && !reset;
    assign bus.enable   = enable_q;
    assign bus.i_data   = i_data_q;
    assign push         = bus.wr_valid && bus.wr_ready;

    sync_fifo #(
        .WIDTH (INPUT_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.wr_data),
        .pop       (launch),
        .head      (head),
        .count     (fifo_count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: assigning a default before the case keeps combinational blocks latch-free.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (!empty && !bus.o_busy) state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.o_busy)                 state_next = ST_WAIT_DONE;
                else if (timer == TIMEOUT_LAST) state_next = AFTER_FRAME;
            end
            ST_WAIT_DONE: if (!bus.o_busy)       state_next = AFTER_FRAME;
            ST_GAP:       if (gap_cnt == '0)     state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        launch      = (state == ST_IDLE) && !empty && !bus.o_busy;
        timeout_hit = (state == ST_WAIT_BUSY) && !bus.o_busy && (timer == TIMEOUT_LAST);
        frame_done  = (state == ST_WAIT_DONE) && !bus.o_busy;
    end

    // i_data only moves on the launch edge, so it stays valid for the whole UART frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q    <= 1'b0;
            i_data_q    <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            tx_timeout  <= 1'b0;
            frames_sent <= '0;
        end else begin
            enable_q <= launch;
            if (launch) begin
                i_data_q <= head;
                timer    <= '0;
            end else if (state == ST_WAIT_BUSY) begin
                timer <= timer + TW'(1);
            end
            if (timeout_hit) tx_timeout  <= 1'b1;
            if (frame_done)  frames_sent <= frames_sent + 16'd1;
            if (timeout_hit || frame_done) gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP)      gap_cnt <= gap_cnt - GW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural UART busy model.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int GAP   = 5;
    localparam int TOUT  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef enum int {BUSY_AUTO, BUSY_HI, BUSY_LO} busy_mode_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] fifo_count;
    logic          empty;
    logic          full;
    logic          tx_timeout;
    logic [15:0]   frames_sent;

    int n_checks = 0;
    int n_fail   = 0;

    busy_mode_t  busy_mode = BUSY_LO;
    int          busy_len  = 88;
    int          cyc       = 0;
    logic [DW-1:0] launched[$];
    int          en_cyc[$];
    int          fall_cyc[$];

    uart_tx_feeder_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_feeder #(
        .INPUT_DATA_WIDTH (DW),
        .FIFO_DEPTH       (DEPTH),
        .GAP_CYCLES       (GAP),
        .BUSY_TIMEOUT     (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fifo_count  (fifo_count),
        .empty       (empty),
        .full        (full),
        .tx_timeout  (tx_timeout),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    // UART model: o_busy rises the cycle after enable and stays high busy_len cycles.
    initial begin : uart_model
        logic pend;
        int   left;
        pend = 1'b0;
        left = 0;
        bus.o_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.enable === 1'b1) begin
                launched.push_back(bus.i_data);
                en_cyc.push_back(cyc);
            end
            case (busy_mode)
                BUSY_HI: begin bus.o_busy = 1'b1; pend = 1'b0; left = 0; end
                BUSY_LO: begin bus.o_busy = 1'b0; pend = 1'b0; left = 0; end
                default: begin
                    if (pend) begin
                        bus.o_busy = 1'b1;
                        left = busy_len;
                        pend = 1'b0;
                    end else if (left > 0) begin
                        left--;
                        if (left == 0) begin
                            bus.o_busy = 1'b0;
                            fall_cyc.push_back(cyc);
                        end
                    end else begin
                        bus.o_busy = 1'b0;
                    end
                end
            endcase
            if (bus.enable === 1'b1 && busy_mode == BUSY_AUTO) pend = 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        tick(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_enable(input int bound, input string tag);
        int n = 0;
        while (bus.enable !== 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.enable), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int bound, input string tag);
        int n = 0;
        while (frames_sent !== 16'(target) && n < bound) begin
            tick(1);
            n++;
        end
        check(tag, 32'(frames_sent), 32'(target));
    endtask

    task automatic clear_log();
        launched.delete();
        en_cyc.delete();
        fall_cyc.delete();
    endtask

    initial begin : stimulus
        int bad;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        reset        = 1'b1;

        // Reset values
        tick(2);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_enable",   32'(bus.enable),   32'd0);
        check("rst_i_data",   32'(bus.i_data),   32'd0);
        check("rst_count",    32'(fifo_count),   32'd0);
        check("rst_empty",    32'(empty),        32'd1);
        check("rst_full",     32'(full),         32'd0);
        check("rst_timeout",  32'(tx_timeout),   32'd0);
        check("rst_frames",   32'(frames_sent),  32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        tick(2);

        // Single byte, 88-cycle frame
        busy_mode = BUSY_AUTO;
        busy_len  = 88;
        clear_log();
        push(8'hA5);
        check("single_count_e0",  32'(fifo_count), 32'd1);
        check("single_no_fallth", 32'(bus.enable), 32'd0);
        tick(1);
        check("single_enable_e1", 32'(bus.enable), 32'd1);
        check("single_i_data",    32'(bus.i_data), 32'hA5);
        check("single_empty",     32'(empty),      32'd1);
        tick(1);
        check("single_enable_1cy", 32'(bus.enable), 32'd0);
        bad = 0;
        for (int i = 0; i < 120 && frames_sent == 16'd0; i++) begin
            if (bus.i_data !== 8'hA5) bad++;
            tick(1);
        end
        check("single_i_data_hold", 32'(bad), 32'd0);
        check("single_frames",      32'(frames_sent), 32'd1);
        check("single_pulses",      32'(launched.size()), 32'd1);
        check("single_i_data_end",  32'(bus.i_data), 32'hA5);
        tick(10);

        // Busy timeout: o_busy never rises
        busy_mode = BUSY_LO;
        push(8'h3C);
        tick(1);
        check("tout_launch", 32'(bus.enable), 32'd1);
        tick(3);
        check("tout_not_yet", 32'(tx_timeout), 32'd0);
        tick(1);
        check("tout_set", 32'(tx_timeout), 32'd1);
        tick(8);
        busy_mode = BUSY_AUTO;
        busy_len  = 10;
        clear_log();
        push(8'h5A);
        wait_enable(20, "tout_next_launch");
        check("tout_next_i_data", 32'(bus.i_data), 32'h5A);
        wait_frames(2, 100, "tout_next_frames");
        check("tout_sticky", 32'(tx_timeout), 32'd1);
        tick(10);

        // Inter-frame gap between two queued bytes
        busy_mode = BUSY_HI;
        tick(2);
        clear_log();
        push(8'h11);
        push(8'h22);
        check("gap_count_q", 32'(fifo_count), 32'd2);
        busy_mode = BUSY_AUTO;
        busy_len  = 20;
        wait_frames(4, 200, "gap_frames");
        tick(2);
        check("gap_launches", 32'(launched.size()), 32'd2);
        check("gap_order0",   32'(launched[0]), 32'h11);
        check("gap_order1",   32'(launched[1]), 32'h22);
        check("gap_spacing",  32'(en_cyc[1] - fall_cyc[0]), 32'd7);
        tick(10);

        // Fill the FIFO while the UART is stuck busy
        busy_mode = BUSY_HI;
        tick(2);
        clear_log();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            tick(1);
        end
        check("fill_full",     32'(full),         32'd1);
        check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("fill_count",    32'(fifo_count),   32'd16);
        bus.wr_data = 8'hEE;
        tick(1);
        bus.wr_valid = 1'b0;
        check("fill_17th_rejected", 32'(fifo_count), 32'd16);
        busy_mode = BUSY_AUTO;
        busy_len  = 3;
        wait_frames(20, 1000, "fill_frames");
        tick(2);
        check("fill_launches", 32'(launched.size()), 32'd16);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (launched[i] !== 8'(i)) bad++;
        end
        check("fill_order", 32'(bad), 32'd0);
        check("fill_empty", 32'(empty), 32'd1);
        tick(10);

        // Push on the same edge as a pop
        busy_mode = BUSY_HI;
        tick(2);
        clear_log();
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("sim_count_pre", 32'(fifo_count), 32'd3);
        busy_mode = BUSY_AUTO;
        busy_len  = 5;
        tick(1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h34;
        tick(1);
        bus.wr_valid = 1'b0;
        check("sim_pop_edge", 32'(bus.enable), 32'd1);
        check("sim_count",    32'(fifo_count), 32'd3);
        check("sim_i_data",   32'(bus.i_data), 32'h31);
        wait_frames(24, 500, "sim_frames");
        tick(2);
        check("sim_launches", 32'(launched.size()), 32'd4);
        check("sim_order3",   32'(launched[3]), 32'h34);
        check("sim_order1",   32'(launched[1]), 32'h32);
        tick(10);

        // Reset in the middle of a frame
        busy_mode = BUSY_AUTO;
        busy_len  = 50;
        push(8'h41);
        wait_enable(20, "rstmid_launch");
        for (int i = 0; i < 4; i++) push(8'(8'h42 + i));
        tick(2);
        check("rstmid_count_pre", 32'(fifo_count), 32'd4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstmid_count",  32'(fifo_count),  32'd0);
        check("rstmid_enable", 32'(bus.enable),  32'd0);
        check("rstmid_i_data", 32'(bus.i_data),  32'd0);
        check("rstmid_frames", 32'(frames_sent), 32'd0);
        check("rstmid_busy",   32'(bus.o_busy),  32'd1);
        clear_log();
        push(8'h66);
        wait_enable(100, "rstmid_next_launch");
        check("rstmid_next_i_data", 32'(bus.i_data), 32'h66);
        check("rstmid_after_fall",  32'(en_cyc[0] - fall_cyc[0]), 32'd1);
        wait_frames(1, 200, "rstmid_next_frames");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
